// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: state encodings,
// default sizing and the encoded write-enable vector layout.
package pipe_ctrl_pkg;

    // Default sizing for the 16-bit core
    localparam int REG_W_DEF        = 4;
    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int CNT_W_DEF        = 16;

    // Controller states, kept as plain constants so the CPU top can compare them directly
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // Write-enable vector ordering: {pc, ifid, idex, exmem, memwb}
    localparam logic [4:0] WEN_ALL    = 5'b11111;
    localparam logic [4:0] WEN_NONE   = 5'b00000;
    localparam logic [4:0] WEN_HOLDFE = 5'b00111;

    // Controls driven into the pipeline registers in one cycle
    typedef struct packed {
        logic [4:0] wen;
        logic       ifid_flush;
        logic       idex_bubble;
    } pipe_ctl_t;

    // Builds a control word from its parts
    function automatic pipe_ctl_t make_ctl(input logic [4:0] wen,
                                           input logic       flush,
                                           input logic       bubble);
        pipe_ctl_t c;
        c.wen         = wen;
        c.ifid_flush  = flush;
        c.idex_bubble = bubble;
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register a
// load in EX is about to write. R0 never creates a hazard since it reads as zero.
module load_use_detect #(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_dst,
    output logic             hazard
);

    logic rs_match;
    logic rt_match;
    logic dst_nonzero;

    // Compare each consumed source against the load destination, excluding R0
    always_comb begin
        rs_match    = id_uses_rs && (id_rs == ex_dst);
        rt_match    = id_uses_rt && (id_rt == ex_dst);
        dst_nonzero = (ex_dst != '0);
        hazard      = ex_memread && dst_nonzero && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: generates write enables, IF/ID flush and
// ID/EX bubble for the 5-stage core, handling memory stalls, taken branches,
// load-use hazards and HLT draining, plus a stall-cycle performance counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W        = REG_W_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_halt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             idex_wen,
    output logic             exmem_wen,
    output logic             memwb_wen,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    // Drain counter reload value; the counter is two bits wide
    localparam logic [1:0] DRAIN_INIT = 2'(DRAIN_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [1:0] drain_cnt;
    logic [1:0] drain_cnt_next;
    logic       hazard;
    pipe_ctl_t  ctl;

    load_use_detect #(
        .REG_W(REG_W)
    ) u_load_use_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_memread (ex_memread),
        .ex_dst     (ex_dst),
        .hazard     (hazard)
    );

    // Priority resolution of pipeline controls and next-state/drain-counter logic
    always_comb begin
        ctl            = make_ctl(WEN_NONE, 1'b0, 1'b0);
        state_next     = state;
        drain_cnt_next = drain_cnt;
        case (state)
            ST_RUN: begin
                if (mem_busy) begin
                    ctl = make_ctl(WEN_NONE, 1'b0, 1'b0);
                end else if (ex_branch_taken) begin
                    ctl = make_ctl(WEN_ALL, 1'b1, 1'b1);
                end else if (hazard) begin
                    ctl = make_ctl(WEN_HOLDFE, 1'b0, 1'b1);
                end else if (id_halt) begin
                    ctl            = make_ctl(WEN_HOLDFE, 1'b0, 1'b1);
                    state_next     = ST_DRAIN;
                    drain_cnt_next = DRAIN_INIT;
                end else begin
                    ctl = make_ctl(WEN_ALL, 1'b0, 1'b0);
                end
            end
            ST_DRAIN: begin
                if (mem_busy) begin
                    ctl = make_ctl(WEN_NONE, 1'b0, 1'b1);
                end else begin
                    ctl = make_ctl(WEN_HOLDFE, 1'b0, 1'b1);
                    if (drain_cnt == 2'd0) begin
                        state_next = ST_HALTED;
                    end else begin
                        drain_cnt_next = drain_cnt - 2'd1;
                    end
                end
            end
            ST_HALTED: begin
                ctl = make_ctl(WEN_NONE, 1'b0, 1'b0);
            end
            default: begin
                ctl        = make_ctl(WEN_NONE, 1'b0, 1'b0);
                state_next = ST_RUN;
            end
        endcase
    end

    // Fan the control word out to the individual pipeline-register controls
    always_comb begin
        pc_wen      = ctl.wen[4];
        ifid_wen    = ctl.wen[3];
        idex_wen    = ctl.wen[2];
        exmem_wen   = ctl.wen[1];
        memwb_wen   = ctl.wen[0];
        ifid_flush  = ctl.ifid_flush;
        idex_bubble = ctl.idex_bubble;
    end

    // State, drain counter and registered halted flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            drain_cnt <= 2'd0;
            halted    <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            halted    <= (state_next == ST_HALTED);
        end
    end

    // Saturating count of cycles where the PC is held while the core is live
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((state == ST_RUN || state == ST_DRAIN) && !pc_wen
                     && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl. The stall counter is narrowed to
// 3 bits so saturation can be reached in a few cycles.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_rs, id_rt, ex_dst;
    logic       id_uses_rs, id_uses_rt, id_halt, ex_memread, ex_branch_taken, mem_busy;
    logic       pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
    logic       ifid_flush, idex_bubble, halted;
    logic [2:0] stall_cnt;
    logic [4:0] wen;

    int checks = 0;
    int errors = 0;

    assign wen = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen};

    pipe_ctrl #(.REG_W(4), .DRAIN_CYCLES(3), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_halt(id_halt), .ex_memread(ex_memread), .ex_dst(ex_dst),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_wen(pc_wen), .ifid_wen(ifid_wen), .idex_wen(idex_wen),
        .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 4'd0; id_rt = 4'd0; ex_dst = 4'd0;
        id_uses_rs = 0; id_uses_rt = 0; id_halt = 0;
        ex_memread = 0; ex_branch_taken = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (wen !== 5'b11111) begin errors++; $display("[TB] FAIL reset_wen got %b want 11111", wen); end
        checks++;
        if ({ifid_flush, idex_bubble, halted} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_ctl got %b want 000", {ifid_flush, idex_bubble, halted});
        end
        checks++;
        if (stall_cnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d want 0", stall_cnt); end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_memread = 1; ex_dst = 4'd3; id_rs = 4'd3; id_uses_rs = 1;
        #1;
        checks++;
        if ({wen, ifid_flush, idex_bubble} !== 7'b0011101) begin
            errors++; $display("[TB] FAIL lu_stall got %b want 0011101", {wen, ifid_flush, idex_bubble});
        end
        step();
        ex_memread = 0;
        #1;
        checks++;
        if ({wen, idex_bubble} !== 6'b111110) begin
            errors++; $display("[TB] FAIL lu_release got %b want 111110", {wen, idex_bubble});
        end
        checks++;
        if (stall_cnt !== 3'd1) begin errors++; $display("[TB] FAIL lu_cnt got %0d want 1", stall_cnt); end
        // rt match but rt not used: no hazard
        ex_memread = 1; ex_dst = 4'd5; id_rs = 4'd1; id_rt = 4'd5; id_uses_rs = 1; id_uses_rt = 0;
        #1;
        checks++;
        if (wen !== 5'b11111) begin errors++; $display("[TB] FAIL lu_rt_unused got %b want 11111", wen); end
        id_uses_rt = 1;
        #1;
        checks++;
        if (wen !== 5'b00111) begin errors++; $display("[TB] FAIL lu_rt got %b want 00111", wen); end
        idle_inputs();
    endtask

    task automatic test_r0();
        do_reset();
        ex_memread = 1; ex_dst = 4'd0; id_rs = 4'd0; id_uses_rs = 1; id_rt = 4'd0; id_uses_rt = 1;
        #1;
        checks++;
        if ({wen, idex_bubble} !== 6'b111110) begin
            errors++; $display("[TB] FAIL r0_nostall got %b want 111110", {wen, idex_bubble});
        end
        step();
        checks++;
        if (stall_cnt !== 3'd0) begin errors++; $display("[TB] FAIL r0_cnt got %0d want 0", stall_cnt); end
        idle_inputs();
    endtask

    task automatic test_branch_priority();
        do_reset();
        ex_branch_taken = 1; id_halt = 1; ex_memread = 1; ex_dst = 4'd7; id_rt = 4'd7; id_uses_rt = 1;
        #1;
        checks++;
        if ({wen, ifid_flush, idex_bubble} !== 7'b1111111) begin
            errors++; $display("[TB] FAIL br_prio got %b want 1111111", {wen, ifid_flush, idex_bubble});
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if ({wen, ifid_flush, idex_bubble} !== 7'b1111100) begin
            errors++; $display("[TB] FAIL br_stays_run got %b want 1111100", {wen, ifid_flush, idex_bubble});
        end
        checks++;
        if (stall_cnt !== 3'd0) begin errors++; $display("[TB] FAIL br_cnt got %0d want 0", stall_cnt); end
    endtask

    task automatic test_busy_defers_hazard();
        do_reset();
        mem_busy = 1; ex_memread = 1; ex_dst = 4'd2; id_rs = 4'd2; id_uses_rs = 1;
        #1;
        checks++;
        if ({wen, ifid_flush, idex_bubble} !== 7'b0000000) begin
            errors++; $display("[TB] FAIL busy_hz got %b want 0000000", {wen, ifid_flush, idex_bubble});
        end
        step();
        mem_busy = 0;
        #1;
        checks++;
        if ({wen, idex_bubble} !== 6'b001111) begin
            errors++; $display("[TB] FAIL busy_hz_retry got %b want 001111", {wen, idex_bubble});
        end
        step();
        checks++;
        if (stall_cnt !== 3'd2) begin errors++; $display("[TB] FAIL busy_hz_cnt got %0d want 2", stall_cnt); end
        idle_inputs();
    endtask

    task automatic test_halt_drain();
        do_reset();
        id_halt = 1;
        #1;
        checks++;
        if ({wen, idex_bubble} !== 6'b001111) begin
            errors++; $display("[TB] FAIL halt_accept got %b want 001111", {wen, idex_bubble});
        end
        step();
        id_halt = 0; ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({wen, ifid_flush, idex_bubble, halted} !== 8'b00111010) begin
                errors++; $display("[TB] FAIL drain_%0d got %b want 00111010", i, {wen, ifid_flush, idex_bubble, halted});
            end
            step();
        end
        ex_branch_taken = 0;
        #1;
        checks++;
        if ({wen, halted} !== 6'b000001) begin errors++; $display("[TB] FAIL halted got %b want 000001", {wen, halted}); end
        checks++;
        if (stall_cnt !== 3'd4) begin errors++; $display("[TB] FAIL halt_cnt got %0d want 4", stall_cnt); end
        step(); step();
        checks++;
        if ({wen, halted, stall_cnt} !== 9'b000001100) begin
            errors++; $display("[TB] FAIL halt_hold got %b want 000001100", {wen, halted, stall_cnt});
        end
        // reset out of HALTED
        rst = 1;
        step();
        rst = 0;
        #1;
        checks++;
        if ({wen, halted, stall_cnt} !== 9'b111110000) begin
            errors++; $display("[TB] FAIL halt_reset got %b want 111110000", {wen, halted, stall_cnt});
        end
    endtask

    task automatic test_halt_busy();
        logic [4:0] exp_wen [0:4];
        exp_wen = '{5'b00111, 5'b00000, 5'b00000, 5'b00111, 5'b00111};
        do_reset();
        id_halt = 1;
        step();
        id_halt = 0;
        for (int i = 0; i < 5; i++) begin
            mem_busy = (i == 1 || i == 2);
            #1;
            checks++;
            if ({wen, halted} !== {exp_wen[i], 1'b0}) begin
                errors++; $display("[TB] FAIL drain_busy_%0d got %b want %b", i, {wen, halted}, {exp_wen[i], 1'b0});
            end
            step();
        end
        mem_busy = 0;
        #1;
        checks++;
        if ({wen, halted, stall_cnt} !== 9'b000001110) begin
            errors++; $display("[TB] FAIL drain_busy_end got %b want 000001110", {wen, halted, stall_cnt});
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        id_halt = 1;
        step();
        id_halt = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        #1;
        checks++;
        if ({wen, idex_bubble, halted, stall_cnt} !== 10'b1111100000) begin
            errors++; $display("[TB] FAIL drain_reset got %b want 1111100000", {wen, idex_bubble, halted, stall_cnt});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_busy = 1;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (stall_cnt !== 3'd7) begin errors++; $display("[TB] FAIL sat_cnt got %0d want 7", stall_cnt); end
        mem_busy = 0;
        step();
        checks++;
        if (stall_cnt !== 3'd7) begin errors++; $display("[TB] FAIL sat_hold got %0d want 7", stall_cnt); end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        test_reset();
        test_load_use();
        test_r0();
        test_branch_priority();
        test_busy_defers_hazard();
        test_halt_drain();
        test_halt_busy();
        test_reset_mid_drain();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
